// File: rtl/universal_shift_seq.sv
// Universal shift register with hold/shift/rotate/arithmetic/load modes and a
// counted multi-shift sequence with busy/done handshake.
module universal_shift_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             start,
    input  logic [CNT_W-1:0] cnt,
    input  logic [WIDTH-1:0] d,
    input  logic             r_in,
    input  logic             l_in,
    output logic [WIDTH-1:0] q,
    output logic             so_r,
    output logic             so_l,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] ModeHold  = 3'b000;
    localparam logic [2:0] ModeShr   = 3'b001;
    localparam logic [2:0] ModeShl   = 3'b010;
    localparam logic [2:0] ModeLoad  = 3'b011;
    localparam logic [2:0] ModeRor   = 3'b100;
    localparam logic [2:0] ModeRol   = 3'b101;
    localparam logic [2:0] ModeAsr   = 3'b110;
    localparam logic [2:0] ModeHold2 = 3'b111;

    logic [WIDTH-1:0] q_q, q_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [2:0]       mode_q, mode_d;

    function automatic logic [WIDTH-1:0] step_fn(
        input logic [2:0]       m,
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] ld,
        input logic             ri,
        input logic             li
    );
        logic [WIDTH-1:0] nxt;
        case (m)
            ModeShr:  nxt = {ri, cur[WIDTH-1:1]};
            ModeShl:  nxt = {cur[WIDTH-2:0], li};
            ModeLoad: nxt = ld;
            ModeRor:  nxt = {cur[0], cur[WIDTH-1:1]};
            ModeRol:  nxt = {cur[WIDTH-2:0], cur[WIDTH-1]};
            ModeAsr:  nxt = {cur[WIDTH-1], cur[WIDTH-1:1]};
            default:  nxt = cur;
        endcase
        return nxt;
    endfunction

    // Load and hold cannot be repeated meaningfully, so a start with them is one step.
    function automatic logic single_step_mode(input logic [2:0] m);
        return (m == ModeHold) || (m == ModeLoad) || (m == ModeHold2);
    endfunction

    always_comb begin
        q_d    = q_q;
        rem_d  = rem_q;
        busy_d = busy_q;
        mode_d = mode_q;
        done_d = 1'b0;
        if (en) begin
            if (busy_q) begin
                q_d   = step_fn(mode_q, q_q, d, r_in, l_in);
                rem_d = rem_q - CNT_W'(1);
                if (rem_q == CNT_W'(1)) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end
            end else if (start) begin
                mode_d = mode;
                done_d = 1'b1;
                if (cnt != '0) begin
                    q_d = step_fn(mode, q_q, d, r_in, l_in);
                    if (cnt != CNT_W'(1) && !single_step_mode(mode)) begin
                        rem_d  = cnt - CNT_W'(1);
                        busy_d = 1'b1;
                        done_d = 1'b0;
                    end
                end
            end else begin
                q_d = step_fn(mode, q_q, d, r_in, l_in);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q    <= '0;
            rem_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            mode_q <= ModeHold;
        end else begin
            q_q    <= q_d;
            rem_q  <= rem_d;
            busy_q <= busy_d;
            done_q <= done_d;
            mode_q <= mode_d;
        end
    end

    assign q    = q_q;
    assign so_r = q_q[0];
    assign so_l = q_q[WIDTH-1];
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_universal_shift_seq.sv
// Scoreboard bench for universal_shift_seq: directed scenarios with fixed
// expectations, then randomised traffic checked against a behavioural model.
module tb_universal_shift_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [2:0] mode;
    logic       start;
    logic [3:0] cnt;
    logic [7:0] d;
    logic       r_in;
    logic       l_in;
    logic [7:0] q;
    logic       so_r;
    logic       so_l;
    logic       busy;
    logic       done;

    universal_shift_seq #(.WIDTH(8), .CNT_W(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .mode (mode),
        .start(start),
        .cnt  (cnt),
        .d    (d),
        .r_in (r_in),
        .l_in (l_in),
        .q    (q),
        .so_r (so_r),
        .so_l (so_l),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] q;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    task automatic set_in(input logic e, input logic s, input logic [2:0] m,
                          input logic [3:0] c, input logic [7:0] dd,
                          input logic ri, input logic li);
        en = e; start = s; mode = m; cnt = c; d = dd; r_in = ri; l_in = li;
    endtask

    // Push the expectation for the coming edge, then compare just after it.
    task automatic cyc(input string tag, input logic [7:0] eq, input logic eb, input logic ed);
        exp_t e;
        e.q = eq; e.busy = eb; e.done = ed;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({tag, ".q"}, 32'(q), 32'(e.q));
        check({tag, ".busy"}, 32'(busy), 32'(e.busy));
        check({tag, ".done"}, 32'(done), 32'(e.done));
        check({tag, ".so"}, 32'({so_l, so_r}), 32'({e.q[7], e.q[0]}));
    endtask

    function automatic logic [7:0] ref_step(input logic [2:0] m, input logic [7:0] cur,
                                            input logic [7:0] ld, input logic ri,
                                            input logic li);
        case (m)
            3'b001:  return {ri, cur[7:1]};
            3'b010:  return {cur[6:0], li};
            3'b011:  return ld;
            3'b100:  return {cur[0], cur[7:1]};
            3'b101:  return {cur[6:0], cur[7]};
            3'b110:  return {cur[7], cur[7:1]};
            default: return cur;
        endcase
    endfunction

    logic [7:0] mq;
    logic [3:0] mrem;
    logic       mbusy, mdone;
    logic [2:0] mmode;

    task automatic model_edge();
        mdone = 1'b0;
        if (!en) return;
        if (mbusy) begin
            mq   = ref_step(mmode, mq, d, r_in, l_in);
            mrem = mrem - 4'd1;
            if (mrem == 4'd0) begin
                mbusy = 1'b0;
                mdone = 1'b1;
            end
        end else if (start) begin
            mmode = mode;
            if (cnt == 4'd0) begin
                mdone = 1'b1;
            end else if (cnt == 4'd1 || mode == 3'b000 || mode == 3'b011 || mode == 3'b111) begin
                mq    = ref_step(mode, mq, d, r_in, l_in);
                mdone = 1'b1;
            end else begin
                mq    = ref_step(mode, mq, d, r_in, l_in);
                mrem  = cnt - 4'd1;
                mbusy = 1'b1;
            end
        end else begin
            mq = ref_step(mode, mq, d, r_in, l_in);
        end
    endtask

    initial begin
        rst = 1'b1;
        set_in(1'b0, 1'b0, 3'b000, 4'd0, 8'h00, 1'b0, 1'b0);
        #12;
        check("reset.q", 32'(q), 32'h00);
        check("reset.busy", 32'(busy), 32'h0);
        check("reset.done", 32'(done), 32'h0);
        rst = 1'b0;

        // Reset in the middle of a rotate-left sequence
        set_in(1'b1, 1'b0, 3'b011, 4'd0, 8'h81, 1'b0, 1'b0);
        cyc("rm_ld", 8'h81, 1'b0, 1'b0);
        set_in(1'b1, 1'b1, 3'b101, 4'd5, 8'h00, 1'b0, 1'b0);
        cyc("rm_e0", 8'h03, 1'b1, 1'b0);
        set_in(1'b1, 1'b0, 3'b000, 4'd0, 8'h00, 1'b0, 1'b0);
        cyc("rm_e1", 8'h06, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        check("rm_async.q", 32'(q), 32'h00);
        check("rm_async.busy", 32'(busy), 32'h0);
        check("rm_async.done", 32'(done), 32'h0);
        #2 rst = 1'b0;
        cyc("rm_post0", 8'h00, 1'b0, 1'b0);
        cyc("rm_post1", 8'h00, 1'b0, 1'b0);

        // Single-step load then shift right
        set_in(1'b1, 1'b0, 3'b011, 4'd0, 8'hA5, 1'b0, 1'b0);
        cyc("ld", 8'hA5, 1'b0, 1'b0);
        set_in(1'b1, 1'b0, 3'b001, 4'd0, 8'h00, 1'b0, 1'b0);
        cyc("shr", 8'h52, 1'b0, 1'b0);
        check("shr.so_r", 32'(so_r), 32'h0);

        // Rotate-left sequence of 3; start while busy is ignored
        set_in(1'b1, 1'b0, 3'b011, 4'd0, 8'h81, 1'b0, 1'b0);
        cyc("rol_ld", 8'h81, 1'b0, 1'b0);
        set_in(1'b1, 1'b1, 3'b101, 4'd3, 8'h00, 1'b0, 1'b0);
        cyc("rol_e0", 8'h03, 1'b1, 1'b0);
        set_in(1'b1, 1'b1, 3'b011, 4'd7, 8'hFF, 1'b1, 1'b1);
        cyc("rol_e1", 8'h06, 1'b1, 1'b0);
        set_in(1'b1, 1'b0, 3'b011, 4'd0, 8'hFF, 1'b0, 1'b0);
        cyc("rol_e2", 8'h0C, 1'b0, 1'b1);
        set_in(1'b1, 1'b0, 3'b000, 4'd0, 8'h00, 1'b0, 1'b0);
        cyc("rol_idle", 8'h0C, 1'b0, 1'b0);

        // Arithmetic shift right sequence of 2
        set_in(1'b1, 1'b0, 3'b011, 4'd0, 8'h90, 1'b0, 1'b0);
        cyc("asr_ld", 8'h90, 1'b0, 1'b0);
        set_in(1'b1, 1'b1, 3'b110, 4'd2, 8'h00, 1'b0, 1'b0);
        cyc("asr_e0", 8'hC8, 1'b1, 1'b0);
        set_in(1'b1, 1'b0, 3'b000, 4'd0, 8'h00, 1'b0, 1'b0);
        cyc("asr_e1", 8'hE4, 1'b0, 1'b1);
        cyc("asr_idle", 8'hE4, 1'b0, 1'b0);

        // Stalled shift-right sequence of 4 with r_in=1
        set_in(1'b1, 1'b0, 3'b011, 4'd0, 8'h00, 1'b0, 1'b0);
        cyc("stl_ld", 8'h00, 1'b0, 1'b0);
        set_in(1'b1, 1'b1, 3'b001, 4'd4, 8'h00, 1'b1, 1'b0);
        cyc("stl_e0", 8'h80, 1'b1, 1'b0);
        set_in(1'b1, 1'b0, 3'b000, 4'd0, 8'h00, 1'b1, 1'b0);
        cyc("stl_e1", 8'hC0, 1'b1, 1'b0);
        en = 1'b0;
        cyc("stl_s0", 8'hC0, 1'b1, 1'b0);
        cyc("stl_s1", 8'hC0, 1'b1, 1'b0);
        en = 1'b1;
        cyc("stl_e2", 8'hE0, 1'b1, 1'b0);
        cyc("stl_e3", 8'hF0, 1'b0, 1'b1);
        set_in(1'b1, 1'b0, 3'b000, 4'd0, 8'h00, 1'b0, 1'b0);
        cyc("stl_idle", 8'hF0, 1'b0, 1'b0);

        // Zero count: no shift, single done pulse; en=0 afterwards
        set_in(1'b1, 1'b0, 3'b011, 4'd0, 8'h3C, 1'b0, 1'b0);
        cyc("z_ld", 8'h3C, 1'b0, 1'b0);
        set_in(1'b1, 1'b1, 3'b010, 4'd0, 8'h00, 1'b0, 1'b1);
        cyc("z_e0", 8'h3C, 1'b0, 1'b1);
        set_in(1'b0, 1'b0, 3'b010, 4'd0, 8'h00, 1'b0, 1'b1);
        cyc("z_idle", 8'h3C, 1'b0, 1'b0);

        // Randomised traffic against the model
        mq = 8'h3C; mrem = 4'd0; mbusy = 1'b0; mdone = 1'b0; mmode = 3'b000;
        for (int i = 0; i < 400; i++) begin
            set_in(($urandom_range(0, 7) != 0), ($urandom_range(0, 3) == 0),
                   3'($urandom), 4'($urandom), 8'($urandom),
                   1'($urandom), 1'($urandom));
            model_edge();
            cyc("rnd", mq, mbusy, mdone);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/universal_shift_seq.md
# universal_shift_seq

Parametrised universal shift register. It supports hold, logical shift, rotate, arithmetic shift and parallel load, and can run a counted multi-shift sequence with a busy/done handshake. It is the WIDTH-generic successor to the 4-bit mux-plus-flop shift register in the datapath library. It sits between a controller (which issues start/cnt) and serial or parallel datapaths.

## Interface
- WIDTH, 8, register width in bits; must be ≥ 2
- CNT_W, 4, width of the shift-count input; sequences run 0 .. 2^CNT_W-1 shifts
- clk  input  1  single clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- en  input  1  operation enable; when 0, all state holds, including a running sequence
- mode  input  3  000 hold, 001 shift right, 010 shift left, 011 parallel load, 100 rotate right, 101 rotate left, 110 arithmetic shift right, 111 hold
- start  input  1  request a counted sequence of the given mode
- cnt  input  CNT_W  number of shifts in the sequence; sampled with start
- d  input  WIDTH  parallel load data
- r_in  input  1  serial input that enters the MSB on shift right
- l_in  input  1  serial input that enters the LSB on shift left
- q  output  WIDTH  register contents
- so_r  output  1  equals q[0]; combinational
- so_l  output  1  equals q[WIDTH-1]; combinational
- busy  output  1  high while a counted sequence has shifts remaining
- done  output  1  one-cycle pulse after a sequence completes

## Operation
- Reset (asynchronous, immediate, including mid-sequence):
  - q=0, busy=0, done=0
  - remaining-count register = 0, latched mode = 000
- Per-shift functions, applied to q:
  - shift right: {r_in, q[W-1:1]}
  - shift left: {q[W-2:0], l_in}
  - rotate right: {q[0], q[W-1:1]}
  - rotate left: {q[W-2:0], q[W-1]}
  - arithmetic shift right: {q[W-1], q[W-1:1]}
  - load: d
  - hold / 111: q
- r_in and l_in are sampled live at each shift edge; they are not latched at start.
- Idle (busy=0), en=1, start=0: apply the mode function once; done stays 0.
- Idle, en=1, start=1 (accept edge):
  - latch mode; apply the mode function once.
  - If cnt ≥ 2: rem←cnt-1, busy←1.
  - If cnt = 1: busy stays 0, done←1.
  - If cnt = 0: q unchanged (no shift, even for load), done←1.
  - For load or hold with start, the operation is a single step whatever cnt is (cnt=0 still suppresses it); done←1.
- Busy, en=1:
  - apply the latched mode each edge and decrement rem.
  - On the edge where rem goes 1→0: busy←0, done←1.
  - start, mode, cnt and d are ignored while busy; no queuing.
- en=0 in any state: q, rem, busy and latched mode hold. done is cleared, so it is never stretched.
- done is high for exactly one cycle per accepted start.

## Timing
- Single-step latency: 1 clk (q valid after the edge).
- Sequence of N ≥ 1 shifts with en held high:
  - shifts occur on edges 0 .. N-1, where edge 0 is the accept edge.
  - busy is high after edges 0 .. N-2.
  - done is high in the cycle after edge N-1.
- Back-to-back: start may be reasserted in the cycle done is high, since busy=0 then. It is accepted on that edge.
- Stalls (en=0) lengthen the sequence by one cycle each; the shift count is unaffected.
- so_r and so_l track q with zero latency.
- Reset assertion clears all outputs without waiting for clk. Release is synchronous to the next edge.

## Test plan
- Reset mid-sequence: start rotate-left cnt=5 on 0x81, assert rst after 2 edges → q=0x00, busy=0, done=0 immediately; no done pulse follows.
- Single-step load and shift: mode=011, d=0xA5, en=1 → q=0xA5, done=0. Next edge, mode=001, r_in=0 → q=0x52, so_r=0.
- Rotate-left sequence: q=0x81, start, mode=101, cnt=3 → q=0x03, 0x06, 0x0C on successive edges. busy=1 for 2 cycles; done pulses once in the cycle after the third edge. A start asserted while busy is ignored.
- Arithmetic shift right: q=0x90, start, mode=110, cnt=2 → q=0xC8, then 0xE4; done pulses once.
- Stall: q=0x00, r_in=1, start, mode=001, cnt=4, en low for 2 cycles after the second shift → q=0xF0 after 4 enabled edges (6 cycles total). busy stays high through the stall; a single done pulse.
- Zero count: start with cnt=0 and mode=010 on q=0x3C → q stays 0x3C, busy never high, done high for 1 cycle.
